// File: rtl/pipe_stage_buf.sv
// pipe_stage_buf: multi-lane valid/ready pipeline stage register with a
// two-entry skid buffer. in_ready comes straight from registered state, so
// back-pressure never forms a combinational path back up the pipeline.
// An empty stage presents all-zero data (a nop) on every lane.
module pipe_stage_buf #(
    parameter int unsigned LANES = 7,
    parameter int unsigned WIDTH = 32,
    parameter int unsigned CNT_W = 16
) (
    input  logic                   clk,
    input  logic                   res,
    input  logic                   in_valid,
    output logic                   in_ready,
    input  logic [LANES*WIDTH-1:0] in_data,
    input  logic                   flush,
    output logic                   out_valid,
    input  logic                   out_ready,
    output logic [LANES*WIDTH-1:0] out_data,
    output logic [1:0]             occupancy,
    output logic [CNT_W-1:0]       stall_cnt
);

    localparam int unsigned      DataW  = LANES * WIDTH;
    localparam logic [CNT_W-1:0] CntMax = {CNT_W{1'b1}};
    localparam logic [CNT_W-1:0] CntOne = {{(CNT_W-1){1'b0}}, 1'b1};

    // State encoding equals the number of held entries.
    typedef enum logic [1:0] {
        StEmpty = 2'd0,
        StOne   = 2'd1,
        StFull  = 2'd2
    } state_e;

    state_e             state_q, state_d;
    logic [DataW-1:0]   main_q, main_d;
    logic [DataW-1:0]   skid_q, skid_d;
    logic [CNT_W-1:0]   stall_q, stall_d;

    logic               in_fire;
    logic               out_fire;
    logic               stalled;

    // Handshake outputs, all derived from registered state only.
    always_comb begin
        in_ready  = (state_q != StFull);
        out_valid = (state_q != StEmpty);
        out_data  = main_q;
        occupancy = state_q;
        stall_cnt = stall_q;
        in_fire   = in_valid & in_ready;
        out_fire  = out_valid & out_ready;
        stalled   = out_valid & ~out_ready;
    end

    // Next state and storage; any path into StEmpty clears both registers.
    always_comb begin
        state_d = state_q;
        main_d  = main_q;
        skid_d  = skid_q;

        unique case (state_q)
            StEmpty: begin
                if (in_fire) begin
                    state_d = StOne;
                    main_d  = in_data;
                end
            end
            StOne: begin
                if (in_fire && out_fire) begin
                    main_d = in_data;
                end else if (in_fire) begin
                    state_d = StFull;
                    skid_d  = in_data;
                end else if (out_fire) begin
                    state_d = StEmpty;
                    main_d  = '0;
                    skid_d  = '0;
                end
            end
            StFull: begin
                // in_ready is low here, so only the pop side can move.
                if (out_fire) begin
                    state_d = StOne;
                    main_d  = skid_q;
                    skid_d  = '0;
                end
            end
            default: begin
                state_d = StEmpty;
                main_d  = '0;
                skid_d  = '0;
            end
        endcase

        // Flush wins over the handshake; a same-cycle push is dropped.
        if (flush) begin
            state_d = StEmpty;
            main_d  = '0;
            skid_d  = '0;
        end
    end

    // Saturating back-pressure counter; survives flush.
    always_comb begin
        stall_d = stall_q;
        if (stalled && (stall_q != CntMax)) begin
            stall_d = stall_q + CntOne;
        end
    end

    // Occupancy state register with synchronous active-low reset.
    always_ff @(posedge clk) begin
        if (!res) begin
            state_q <= StEmpty;
        end else begin
            state_q <= state_d;
        end
    end

    // Head and skid data registers, cleared to a bubble on reset.
    always_ff @(posedge clk) begin
        if (!res) begin
            main_q <= '0;
            skid_q <= '0;
        end else begin
            main_q <= main_d;
            skid_q <= skid_d;
        end
    end

    // Stall counter register, cleared only by reset.
    always_ff @(posedge clk) begin
        if (!res) begin
            stall_q <= '0;
        end else begin
            stall_q <= stall_d;
        end
    end

endmodule

// File: doc/pipe_stage_buf.md
# pipe_stage_buf

Parametrised pipeline stage register for the next-generation five-stage MIPS core, replacing fixed-width, enable-only stage registers (e.g. E→M) with a multi-lane, valid/ready handshaked stage. It carries LANES independent WIDTH-bit fields (instruction word, PC, ALU result, HI, LO, …) and has a 2-entry skid buffer so that `in_ready` is fully registered. It also supports flush-to-bubble and a saturating back-pressure counter for performance debug. One instance sits between each pair of adjacent pipeline stages.

## Interface
- LANES, 7, number of fields carried per entry
- WIDTH, 32, width of each field in bits
- CNT_W, 16, width of stall counter
- clk  input  1  single clock, all state updates on rising edge
- res  input  1  synchronous, active-low reset (res==0 resets on clk edge)
- in_valid  input  1  upstream stage presents an entry
- in_ready  output  1  buffer accepts an entry this cycle
- in_data  input  LANES*WIDTH  lane k at bits [k*WIDTH +: WIDTH]
- flush  input  1  discard all held entries, emit bubble
- out_valid  output  1  downstream entry valid
- out_ready  input  1  downstream consumes entry this cycle
- out_data  output  LANES*WIDTH  head entry, same lane packing
- occupancy  output  2  entries held (0,1,2)
- stall_cnt  output  CNT_W  cycles with out_valid=1 and out_ready=0

## Operation
- Storage: main register (head, drives out_data) and skid register. The state is the occupancy: EMPTY(0), ONE(1), FULL(2).
- Handshake events: in_fire = in_valid & in_ready; out_fire = out_valid & out_ready.
- in_ready = (occupancy != 2). It depends on registered state only. There is no combinational path from out_ready or in_valid.
- out_valid = (occupancy != 0). out_data = main register.
- Transitions (no flush):
  - EMPTY: in_fire → ONE, main<=in_data. No in_fire → stay in EMPTY.
  - ONE:
    - in_fire & out_fire → ONE, main<=in_data.
    - in_fire only → FULL, skid<=in_data.
    - out_fire only → EMPTY.
    - Neither → hold.
  - FULL: in_ready=0. out_fire → ONE, main<=skid. Otherwise hold.
- Bubble rule: whenever occupancy becomes 0, main and skid are cleared to all-zero. This covers reset, flush and pop-to-empty. An empty stage therefore presents a nop (0x00000000 on every lane).
- Order is strict FIFO. No entry is duplicated or dropped except by flush.
- flush=1: next state is EMPTY and all storage is cleared. Any same-cycle in_fire is discarded. A same-cycle out_fire still counts as consumed by downstream.
- Priority: reset > flush > handshake.
- stall_cnt increments when out_valid & !out_ready. It saturates at 2^CNT_W−1. It is cleared only by reset, not by flush.
- Reset: occupancy=0, out_valid=0, in_ready=1, out_data=0, stall_cnt=0, and all storage is cleared.

## Timing
- Latency: an entry accepted at edge N is visible on out_data/out_valid after edge N (one cycle). No combinational bypass from in_data to out_data.
- Throughput: one entry per cycle sustained while out_ready=1.
- After out_ready deasserts, one further entry can be accepted into skid. in_ready falls on the edge after that acceptance.
- After out_ready reasserts in FULL, the skid entry moves to main at that edge. in_ready is 1 in the following cycle.
- occupancy and in_ready are updated on the same edge as the data registers.
- Reset mid-operation: all held entries are lost, and the state is as in the reset values above, on the edge where res==0 is sampled.

## Test plan
- Reset then stream: res=0 for 2 cycles, then lane0 = 0x1,0x2,0x3… with out_ready=1. Required: out_data lane0 = 0x1,0x2,0x3 one cycle after each acceptance, occupancy=1, in_ready=1 throughout, stall_cnt=0.
- Back-pressure: send 0xA, then 0xB; drop out_ready on the cycle 0xA appears. Required: occupancy=2 and in_ready=0 the next cycle. Hold for 5 cycles: stall_cnt=5 and out_data stays 0xA. Raise out_ready: 0xA is consumed, 0xB appears, in_ready=1.
- Flush while FULL: entries 0x11 and 0x22 are held, and flush=1 is asserted with in_valid=1 and in_data=0x33. Required: next cycle occupancy=0, out_valid=0, out_data=0 on all lanes, and 0x33 is never output. stall_cnt is unchanged.
- Lane packing (LANES=3, WIDTH=8): in_data=0xCCBBAA. Required: out_data=0xCCBBAA. Lane 2 reads 0xCC, lane 0 reads 0xAA.
- Saturation (CNT_W=4): hold out_valid=1 and out_ready=0 for 20 cycles. Required: stall_cnt=15, with no wrap.
- Reset mid-stream: in FULL with stall_cnt=7, drive res=0 for one edge. Required: occupancy=0, in_ready=1, out_data=0, stall_cnt=0 after that edge.
